seg7_scan_controller: RTL and testbench

Time-multiplexes one hex-to-7-segment decoder across DIGITS common-anode digits of a multiplexed display. Holds a double-buffered display value so that a new value is only applied on a frame boundary and no frame is ever torn. Inserts a ghost-suppression blank at the start of every digit slot and supports leading-zero blanking. Sits between system logic, which issues load strobes, and the display pins.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_scan_timer.sv | 36 +++
 rtl/seg7_scan_controller.sv | 74 +++++++
 tb/tb_seg7_scan_controller.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared polarity constants, scan phase type and the hex-to-segment truth table
package seg7_pkg;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEG_DP_ONLY = 8'h7F;
  localparam logic SEG_ON = 1'b0;
  localparam logic AN_ON = 1'b0;
  localparam logic AN_OFF = 1'b1;
  typedef enum logic {PH_BLANK, PH_SHOW} phase_t;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction
endpackage

// File: rtl/seg7_scan_timer.sv
// seg7_scan_timer: slot counter, digit index, blank/show phase and frame-boundary strobe
// ports: clk, rst (sync, active-high), en (0 holds cnt/idx at 0),
//        idx (current digit), phase (BLANK during the ghost window), bnd (frame boundary this cycle)
module seg7_scan_timer import seg7_pkg::*; #(
  parameter int DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GHOST = 1000,
  parameter int IW = cw(DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [IW-1:0] idx,
  output phase_t        phase,
  output logic          bnd
);
  localparam int CW = cw(SCAN_DIV);
  logic [CW-1:0] cnt;
  logic en_q, wrap, last;
  assign wrap = cnt == CW'(SCAN_DIV - 1);
  assign last = idx == IW'(DIGITS - 1);
  assign phase = cnt < CW'(GHOST) ? PH_BLANK : PH_SHOW;
  // the enable hold parks the scan at 0/0, so the first enabled cycle starts a fresh frame
  assign bnd = en && ((wrap && last) || !en_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      en_q <= 1'b0;
    end else begin
      en_q <= en;
      cnt <= (!en || wrap) ? '0 : cnt + 1'b1;
      idx <= !en ? '0 : wrap ? (last ? '0 : idx + 1'b1) : idx;
    end
  end
endmodule

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: double-buffered multiplexed hex display driver with ghost blanking and leading-zero blanking
// ports: clk, rst (sync, active-high), en (scan enable), ld (load val/dp/lzb into pending),
//        val (hex nibbles, nibble 0 = rightmost), dp (per-digit point), lzb (leading-zero blanking),
//        seg ({DP,A..G} active-low), an (anodes active-low), pend (load waiting), frame (active updated)
module seg7_scan_controller import seg7_pkg::*; #(
  parameter int DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GHOST = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   val,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  lzb,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  pend,
  output logic                  frame
);
  localparam int IW = cw(DIGITS);
  logic [IW-1:0] idx;
  phase_t phase;
  logic bnd, z, dark;
  logic [4*DIGITS-1:0] act_val, pnd_val;
  logic [DIGITS-1:0] act_dp, pnd_dp, blk, an_sel;
  logic act_lzb, pnd_lzb;
  logic [3:0] nib;
  logic [7:0] seg_d;
  logic [DIGITS-1:0] an_d;
  seg7_scan_timer #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GHOST(GHOST), .IW(IW)) u_timer (
    .clk(clk), .rst(rst), .en(en), .idx(idx), .phase(phase), .bnd(bnd)
  );
  // a digit is blanked when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    blk = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z & (act_val[4*i +: 4] == 4'h0);
      blk[i] = z & act_lzb;
    end
  end
  assign nib = act_val[4*idx +: 4];
  assign an_sel = ~(DIGITS'(1) << idx);
  // a blanked digit with its point set keeps the anode on to light the point alone
  assign dark = !en || phase == PH_BLANK || (blk[idx] && !act_dp[idx]);
  always_comb begin
    seg_d = dark ? SEG_OFF : blk[idx] ? SEG_DP_ONLY : {act_dp[idx] ? SEG_ON : ~SEG_ON, hex_to_seg(nib)};
    an_d = dark ? {DIGITS{AN_OFF}} : an_sel;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      act_val <= '0;
      act_dp <= '0;
      act_lzb <= 1'b0;
      pnd_val <= '0;
      pnd_dp <= '0;
      pnd_lzb <= 1'b0;
      pend <= 1'b0;
      frame <= 1'b0;
      seg <= SEG_OFF;
      an <= {DIGITS{AN_OFF}};
    end else begin
      seg <= seg_d;
      an <= an_d;
      frame <= bnd && (ld || pend);
      pend <= !bnd && (ld || pend);
      if (bnd && ld) {act_val, act_dp, act_lzb} <= {val, dp, lzb};
      else if (bnd && pend) {act_val, act_dp, act_lzb} <= {pnd_val, pnd_dp, pnd_lzb};
      if (!bnd && ld) {pnd_val, pnd_dp, pnd_lzb} <= {val, dp, lzb};
    end
  end
endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller: directed self-checking bench for the multiplexed display driver
module tb_seg7_scan_controller;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, ld = 1'b0, lzb = 1'b0;
  logic [15:0] val = '0;
  logic [3:0] dp = '0;
  logic [7:0] seg;
  logic [3:0] an;
  logic pend, frame;
  int checks = 0, errors = 0, cyc = 0;
  seg7_scan_controller #(.DIGITS(4), .SCAN_DIV(8), .GHOST(2)) dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .val(val), .dp(dp), .lzb(lzb),
    .seg(seg), .an(an), .pend(pend), .frame(frame)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [3:0] a, input logic [7:0] s);
    chk({tag, " an"}, {4'h0, an}, {4'h0, a});
    chk({tag, " seg"}, seg, s);
  endtask
  task automatic load(input logic [15:0] v, input logic [3:0] d, input logic z);
    val = v;
    dp = d;
    lzb = z;
    ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk_out("reset", 4'hF, 8'hFF);
    chk("reset pend", {7'h0, pend}, 8'h00);
    chk("reset frame", {7'h0, frame}, 8'h00);
    rst = 1'b0;
    load(16'h12AF, 4'b0100, 1'b0);
    chk("load pend", {7'h0, pend}, 8'h01);
    chk_out("disabled dark", 4'hF, 8'hFF);
    en = 1'b1;
    cyc = -1;
    tick();
    chk("enable frame", {7'h0, frame}, 8'h01);
    chk("enable pend", {7'h0, pend}, 8'h00);
    chk_out("ghost c0", 4'hF, 8'hFF);
    tick();
    chk("frame one cycle", {7'h0, frame}, 8'h00);
    goto(2);
    chk_out("d0 F", 4'b1110, 8'hB8);
    goto(7);
    chk_out("d0 slot end", 4'b1110, 8'hB8);
    goto(8);
    chk_out("ghost d1", 4'hF, 8'hFF);
    goto(10);
    chk_out("d1 A", 4'b1101, 8'h88);
    goto(18);
    chk_out("d2 2 dp", 4'b1011, 8'h12);
    goto(26);
    chk_out("d3 1", 4'b0111, 8'hCF);
    load(16'h3333, 4'b0000, 1'b0);
    chk("mid pend", {7'h0, pend}, 8'h01);
    chk_out("mid old", 4'b0111, 8'hCF);
    goto(31);
    chk("bnd frame", {7'h0, frame}, 8'h01);
    chk("bnd pend", {7'h0, pend}, 8'h00);
    chk_out("bnd no tear", 4'b0111, 8'hCF);
    goto(32);
    chk("bnd frame once", {7'h0, frame}, 8'h00);
    goto(34);
    chk_out("new 3", 4'b1110, 8'h86);
    load(16'h1111, 4'b0000, 1'b0);
    goto(44);
    load(16'h2222, 4'b0000, 1'b0);
    chk("dbl pend", {7'h0, pend}, 8'h01);
    goto(50);
    chk_out("dbl hold", 4'b1011, 8'h86);
    goto(63);
    chk("dbl frame", {7'h0, frame}, 8'h01);
    goto(66);
    chk_out("dbl d0 2", 4'b1110, 8'h92);
    goto(90);
    chk_out("dbl d3 2", 4'b0111, 8'h92);
    goto(94);
    load(16'h5555, 4'b0001, 1'b0);
    chk("ldbnd frame", {7'h0, frame}, 8'h01);
    chk("ldbnd pend", {7'h0, pend}, 8'h00);
    goto(98);
    chk_out("ldbnd d0 5dp", 4'b1110, 8'h24);
    chk("ldbnd pend later", {7'h0, pend}, 8'h00);
    goto(100);
    load(16'h0050, 4'b0000, 1'b1);
    goto(127);
    chk("lzb frame", {7'h0, frame}, 8'h01);
    goto(130);
    chk_out("lzb d0 0", 4'b1110, 8'h81);
    goto(138);
    chk_out("lzb d1 5", 4'b1101, 8'hA4);
    goto(146);
    chk_out("lzb d2 dark", 4'hF, 8'hFF);
    goto(154);
    chk_out("lzb d3 dark", 4'hF, 8'hFF);
    goto(155);
    load(16'h0000, 4'b1000, 1'b1);
    goto(159);
    chk("zero frame", {7'h0, frame}, 8'h01);
    goto(162);
    chk_out("zero d0 0", 4'b1110, 8'h81);
    goto(170);
    chk_out("zero d1 dark", 4'hF, 8'hFF);
    goto(178);
    chk_out("zero d2 dark", 4'hF, 8'hFF);
    goto(186);
    chk_out("zero d3 dp only", 4'b0111, 8'h7F);
    goto(188);
    en = 1'b0;
    tick();
    chk_out("en drop dark", 4'hF, 8'hFF);
    load(16'h9999, 4'b0000, 1'b0);
    chk("en off load pend", {7'h0, pend}, 8'h01);
    chk_out("en off dark", 4'hF, 8'hFF);
    rst = 1'b1;
    tick();
    chk("rst pend", {7'h0, pend}, 8'h00);
    chk("rst frame", {7'h0, frame}, 8'h00);
    chk_out("rst dark", 4'hF, 8'hFF);
    rst = 1'b0;
    en = 1'b1;
    tick();
    chk("restart no frame", {7'h0, frame}, 8'h00);
    chk("restart pend", {7'h0, pend}, 8'h00);
    tick();
    tick();
    chk_out("restart d0 0", 4'b1110, 8'h81);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
